// File: rtl/game_seq.sv
// game_seq: top-level game sequencer for the invaders design.
// Gates the player/invader controllers, pulses the object reset and keeps
// lives, score and wave. All outputs are registered.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per frame
//   button_start      debounced start level (rising edge detected here)
//   player_hit        pulse: player struck
//   invader_hit       pulse: invader killed by player bullet
//   invaders_cleared  level: no invaders remain
//   invaders_landed   pulse: formation reached player row
//   state             IDLE=0 PLAY=1 DYING=2 WAVE_CLR=3 GAME_OVER=4
//   play_en           high while state==PLAY
//   obj_rst           one-cycle pulse after each entry to PLAY
//   lives, score, wave, hi_score
//
// Build option: define GAME_SEQ_HISCORE_EN to keep a best-score register;
// otherwise hi_score is tied to zero.
module game_seq #(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned RESPAWN_TICKS = 90,
  parameter int unsigned WAVE_TICKS    = 120,
  parameter int unsigned SCORE_W       = 16,
  parameter int unsigned POINTS        = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               button_start,
  input  logic               player_hit,
  input  logic               invader_hit,
  input  logic               invaders_cleared,
  input  logic               invaders_landed,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               obj_rst,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         wave,
  output logic [SCORE_W-1:0] hi_score
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PLAY      = 3'd1;
  localparam logic [2:0] S_DYING     = 3'd2;
  localparam logic [2:0] S_WAVE_CLR  = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  localparam int unsigned SUM_W = SCORE_W + 33;

  logic               start_q;
  logic               start_rise;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nxt;
  logic [2:0]         lives_dec;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_inc;

  // Edge seen between the previous and current sample acts this edge.
  assign start_rise = button_start & ~start_q;
  assign cnt_nxt    = cnt + 8'd1;
  assign lives_dec  = lives - 3'd1;

  // Wide add so any POINTS value saturates correctly instead of wrapping.
  always_comb begin
    score_sum = {33'd0, score} + SUM_W'(POINTS);
    if (score_sum[SUM_W-1:SCORE_W] != '0) score_inc = '1;
    else                                  score_inc = score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      play_en <= 1'b0;
      obj_rst <= 1'b0;
      lives   <= 3'(LIVES);
      score   <= '0;
      wave    <= 4'd1;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= button_start;
      obj_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state   <= S_PLAY;
            play_en <= 1'b1;
            obj_rst <= 1'b1;
            lives   <= 3'(LIVES);
            score   <= '0;
            wave    <= 4'd1;
          end
        end
        S_PLAY: begin
          // Score accrues even on a cycle that also leaves PLAY.
          if (invader_hit) score <= score_inc;
          if (invaders_landed) begin
            state   <= S_GAME_OVER;
            play_en <= 1'b0;
            lives   <= 3'd0;
          end else if (player_hit) begin
            lives   <= lives_dec;
            play_en <= 1'b0;
            cnt     <= '0;
            state   <= (lives_dec == 3'd0) ? S_GAME_OVER : S_DYING;
          end else if (invaders_cleared) begin
            state   <= S_WAVE_CLR;
            play_en <= 1'b0;
            cnt     <= '0;
          end
        end
        S_DYING: begin
          if (frame_tick) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == 8'(RESPAWN_TICKS)) begin
              state   <= S_PLAY;
              play_en <= 1'b1;
              obj_rst <= 1'b1;
            end
          end
        end
        S_WAVE_CLR: begin
          if (frame_tick) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == 8'(WAVE_TICKS)) begin
              state   <= S_PLAY;
              play_en <= 1'b1;
              obj_rst <= 1'b1;
              if (wave != 4'd15) wave <= wave + 4'd1;
            end
          end
        end
        S_GAME_OVER: begin
          if (start_rise) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          play_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAME_SEQ_HISCORE_EN
  // Score is frozen in GAME_OVER, so updating while there captures the
  // final score one edge after entry.
  always_ff @(posedge clk) begin
    if (rst)                                      hi_score <= '0;
    else if (state == S_GAME_OVER && score > hi_score) hi_score <= score;
  end
`else
  assign hi_score = '0;
`endif

endmodule

// File: tb/tb_game_seq.sv
// Scoreboard bench for game_seq: stimulus pushes expected snapshots, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_game_seq;

`ifdef GAME_SEQ_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ph, ih, clr, land, ft;
  logic [2:0]  state, lives;
  logic        play_en, obj_rst;
  logic [15:0] score, hi_score;
  logic [3:0]  wave;

  logic        s_start, s_ih, s_zero;
  logic [2:0]  s_state, s_lives;
  logic        s_play_en, s_obj_rst;
  logic [3:0]  s_score, s_hi, s_wave;

  game_seq dut (
    .clk(clk), .rst(rst), .frame_tick(ft), .button_start(start),
    .player_hit(ph), .invader_hit(ih), .invaders_cleared(clr),
    .invaders_landed(land), .state(state), .play_en(play_en),
    .obj_rst(obj_rst), .lives(lives), .score(score), .wave(wave),
    .hi_score(hi_score)
  );

  game_seq #(.SCORE_W(4), .POINTS(10)) u_sat (
    .clk(clk), .rst(rst), .frame_tick(s_zero), .button_start(s_start),
    .player_hit(s_zero), .invader_hit(s_ih), .invaders_cleared(s_zero),
    .invaders_landed(s_zero), .state(s_state), .play_en(s_play_en),
    .obj_rst(s_obj_rst), .lives(s_lives), .score(s_score), .wave(s_wave),
    .hi_score(s_hi)
  );

  typedef struct {
    bit          sel;
    logic [2:0]  st;
    logic        orst;
    logic [2:0]  lv;
    logic [15:0] sc;
    logic [3:0]  wv;
    logic [15:0] hi;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [2:0]  e_st, e_lv;
  logic        e_obj;
  logic [15:0] e_sc, e_hi;
  logic [3:0]  e_wv;

  // Monitor: one expected snapshot per cycle at most, compared on negedge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      bit ok;
      e = q.pop_front();
      checks++;
      if (!e.sel)
        ok = (state == e.st) && (play_en == (e.st == 3'd1)) &&
             (obj_rst == e.orst) && (lives == e.lv) && (score == e.sc) &&
             (wave == e.wv) && (hi_score == e.hi);
      else
        ok = (s_state == e.st) && (s_score == e.sc[3:0]);
      if (!ok) begin
        failures++;
        if (!e.sel)
          $display("FAIL %s: got st=%0d pe=%0b orst=%0b lv=%0d sc=%0d wv=%0d hi=%0d, exp st=%0d pe=%0b orst=%0b lv=%0d sc=%0d wv=%0d hi=%0d",
                   e.name, state, play_en, obj_rst, lives, score, wave, hi_score,
                   e.st, (e.st == 3'd1), e.orst, e.lv, e.sc, e.wv, e.hi);
        else
          $display("FAIL %s: got st=%0d sc=%0d, exp st=%0d sc=%0d",
                   e.name, s_state, s_score, e.st, e.sc[3:0]);
      end
    end
  end

  task automatic push(input string name);
    q.push_back('{1'b0, e_st, e_obj, e_lv, e_sc, e_wv, e_hi, name});
  endtask

  task automatic spush(input string name, input logic [2:0] st, input logic [15:0] sc);
    q.push_back('{1'b1, st, 1'b0, 3'd0, sc, 4'd0, 16'd0, name});
  endtask

  task automatic cyc(input logic s, input logic p, input logic i,
                     input logic c, input logic l, input logic f);
    @(negedge clk);
    start = s; ph = p; ih = i; clr = c; land = l; ft = f;
    @(posedge clk);
    #1;
    ph = 1'b0; ih = 1'b0; land = 1'b0; ft = 1'b0;
  endtask

  task automatic scyc(input logic s, input logic i);
    @(negedge clk);
    s_start = s; s_ih = i;
    @(posedge clk);
    #1;
    s_ih = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 0; ph = 0; ih = 0; clr = 0; land = 0; ft = 0;
    s_start = 0; s_ih = 0; s_zero = 0;
    e_st = 3'd0; e_lv = 3'd3; e_sc = 0; e_wv = 4'd1; e_hi = 0; e_obj = 0;

    @(negedge clk); @(posedge clk); #1;
    push("reset");
    @(negedge clk); rst = 1'b0;

    // Start, obj_rst one cycle, held button does not retrigger.
    cyc(1,0,0,0,0,0); e_st = 3'd1; e_obj = 1; push("start_edge");
    cyc(1,0,0,0,0,0); e_obj = 0; push("start_held");
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,1,0,0,0); e_sc = e_sc + 16'd10; push("inv_hit");
    end
    // Hit + score same cycle; coincident tick is not counted.
    cyc(0,1,1,0,0,1); e_sc = 16'd60; e_lv = 3'd2; e_st = 3'd2; push("hit_and_score");
    cyc(1,1,1,0,1,0); push("dying_ignores");
    cyc(0,0,0,0,0,0);
    for (int i = 0; i < 89; i++) cyc(0,0,0,0,0,1);
    push("dying_89");
    cyc(0,0,0,0,0,1); e_st = 3'd1; e_obj = 1; push("respawn");
    cyc(0,0,0,0,0,0); e_obj = 0; push("respawn_obj_end");

    // Wave clear.
    cyc(0,0,0,1,0,1); e_st = 3'd3; push("wave_clr_entry");
    cyc(0,1,0,0,0,1); push("wave_ignore_hit");
    for (int i = 0; i < 118; i++) cyc(0,0,0,0,0,1);
    push("wave_119");
    cyc(0,0,0,0,0,1); e_st = 3'd1; e_wv = 4'd2; e_obj = 1; push("next_wave");

    // Landed beats cleared; score still accrues.
    cyc(0,0,1,1,1,0); e_st = 3'd4; e_lv = 3'd0; e_sc = 16'd70; e_obj = 0; push("landed");
    cyc(0,0,0,0,0,0); if (HI_EN) e_hi = 16'd70; push("game_over_hold");
    cyc(1,0,0,0,0,0); e_st = 3'd0; push("go_to_idle");
    cyc(0,0,0,0,0,0);
    cyc(1,0,0,0,0,0); e_st = 3'd1; e_obj = 1; e_lv = 3'd3; e_sc = 0; e_wv = 4'd1; push("restart");
    cyc(0,0,0,0,0,0); e_obj = 0;
    cyc(0,0,1,0,0,0);
    cyc(0,0,1,0,0,0); e_sc = 16'd20; push("game2_score");

    // Lose all lives at score 20.
    for (int d = 0; d < 3; d++) begin
      cyc(0,1,0,0,0,0);
      e_lv = e_lv - 3'd1;
      e_st = (e_lv == 3'd0) ? 3'd4 : 3'd2;
      push("death");
      if (d < 2) begin
        for (int i = 0; i < 90; i++) cyc(0,0,0,0,0,1);
        e_st = 3'd1; e_obj = 1; push("respawn2");
        cyc(0,0,0,0,0,0); e_obj = 0;
      end
    end
    cyc(0,0,0,0,0,0); push("hi_kept");

    // Reset mid-DYING at tick 40.
    cyc(1,0,0,0,0,0); e_st = 3'd0;
    cyc(0,0,0,0,0,0);
    cyc(1,0,0,0,0,0); e_st = 3'd1; e_obj = 1; e_lv = 3'd3; e_sc = 0; e_wv = 4'd1;
    cyc(0,0,0,0,0,0); e_obj = 0;
    cyc(0,1,0,0,0,0); e_lv = 3'd2; e_st = 3'd2; push("dying_again");
    for (int i = 0; i < 40; i++) cyc(0,0,0,0,0,0 | 1);
    @(negedge clk); rst = 1'b1; ft = 1'b1; start = 1'b0;
    @(posedge clk); #1; ft = 1'b0;
    e_st = 3'd0; e_lv = 3'd3; e_sc = 0; e_wv = 4'd1; e_hi = 0; e_obj = 0;
    push("mid_rst");
    @(negedge clk); rst = 1'b0;
    cyc(0,0,0,0,0,0); push("post_rst");

    // Saturation instance: SCORE_W=4, POINTS=10.
    scyc(1,0); spush("sat_start", 3'd1, 16'd0);
    scyc(0,1); spush("sat_hit1", 3'd1, 16'd10);
    scyc(0,1); spush("sat_hit2", 3'd1, 16'd15);
    scyc(0,1); spush("sat_hit3", 3'd1, 16'd15);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d pending expectations, required 0", q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
